nios2_oci_trace_capture_monitor: RTL

- Parametrised capture/checker that replaces the passive OCI test-bench stub.
- Watches the debug-trace compressor outputs (dct_buffer, dct_count) and records each new trace word in a circular buffer.
- Keeps a running signature and event count.
- Drains the buffer through a valid/ready port once the test signals it is ending. It sits beside the nios2 OCI block in simulation and debug builds.

---
 rtl/nios2_oci_trace_capture_monitor_pkg.sv | 28 ++
 rtl/nios2_oci_trace_capture_monitor_if.sv | 14 +
 rtl/nios2_oci_trace_ring.sv | 66 ++++++
 rtl/nios2_oci_trace_capture_monitor.sv | 119 +++++++++++
 4 files changed

// File: rtl/nios2_oci_trace_capture_monitor_pkg.sv
// Shared types and helpers for the OCI trace capture monitor.
//   state_e    : capture session state (idle, capture, drain, done)
//   sig_rotl1  : rotate-left-by-one of a value that is w bits wide (w <= SigMaxW)
//   sat_inc16  : 16-bit increment that sticks at 0xFFFF
package nios2_oci_tb_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StCapture,
        StDrain,
        StDone
    } state_e;

    // Widest signature the rotate helper supports.
    localparam int unsigned SigMaxW = 64;

    function automatic logic [SigMaxW-1:0] sig_rotl1(input logic [SigMaxW-1:0] v,
                                                     input int unsigned         w);
        logic [SigMaxW-1:0] mask;
        mask = (w >= SigMaxW) ? '1 : ((SigMaxW'(1) << w) - SigMaxW'(1));
        return ((v << 1) | (v >> (w - 1))) & mask;
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/nios2_oci_trace_capture_monitor_if.sv
// Drain port of the trace capture monitor: valid/ready stream of captured trace words.
//   rd_valid : an entry is presented
//   rd_ready : consumer accepts the entry this cycle
//   rd_data  : oldest buffered entry
interface nios2_oci_trace_capture_monitor_if #(
    parameter int unsigned BUF_W = 30
);
    logic             rd_valid;
    logic             rd_ready;
    logic [BUF_W-1:0] rd_data;

    modport master (output rd_valid, output rd_data, input rd_ready);
    modport slave  (input rd_valid, input rd_data, output rd_ready);
endinterface

// File: rtl/nios2_oci_trace_ring.sv
// DEPTH x BUF_W register-array circular buffer.
//   clear     : synchronous return to empty (pointers and count)
//   push      : write wdata at the write pointer
//   overwrite : with push, replace the oldest entry (caller asserts only when full)
//   pop       : retire the entry at the read pointer
//   rdata     : entry at the read pointer, combinational
//   full/empty/count : occupancy, count in 0..DEPTH
module nios2_oci_trace_ring #(
    parameter int unsigned BUF_W = 30,
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     clear,
    input  logic                     push,
    input  logic                     overwrite,
    input  logic                     pop,
    input  logic [BUF_W-1:0]         wdata,
    output logic [BUF_W-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [BUF_W-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    count_q;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign rdata = mem[rd_ptr_q];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (clear) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            // An overwrite retires the oldest entry as the new one lands.
            if (pop || (push && overwrite)) rd_ptr_q <= rd_ptr_q + AW'(1);
            if (push && !overwrite && !pop) begin
                count_q <= count_q + CW'(1);
            end else if (pop && !push) begin
                count_q <= count_q - CW'(1);
            end
        end
    end

    // Contents are cleared on reset so the drain data output reads zero out of reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
        end else if (push) begin
            mem[wr_ptr_q] <= wdata;
        end
    end

endmodule

// File: rtl/nios2_oci_trace_capture_monitor.sv
// Trace capture monitor: records each new debug-trace word (marked by a change of dct_count)
// into a ring buffer while capturing, keeps a rotate-XOR signature and an event count, and
// drains the buffer over a valid/ready port once the test is ending.
//   clk, reset_n          : clock, asynchronous active-low reset
//   arm                   : pulse starting a session (from idle or done)
//   dct_buffer, dct_count : trace compressor data word and count
//   test_ending           : level, leave capture and start draining
//   test_has_ended        : level, sets the sticky ended flag; also leaves capture
//   rd                    : drain stream (master side)
//   entry_count           : entries held; total_count: events this session (saturating)
//   overflow              : sticky, event hit a full buffer; signature: running signature
//   busy, done            : capturing or draining / session finished
// BUF_W must not exceed nios2_oci_tb_pkg::SigMaxW.
module nios2_oci_trace_capture_monitor
    import nios2_oci_tb_pkg::*;
#(
    parameter int unsigned BUF_W     = 30,
    parameter int unsigned CNT_W     = 4,
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned OVERWRITE = 0
) (
    input  logic                                    clk,
    input  logic                                    reset_n,
    input  logic                                    arm,
    input  logic [BUF_W-1:0]                        dct_buffer,
    input  logic [CNT_W-1:0]                        dct_count,
    input  logic                                    test_ending,
    input  logic                                    test_has_ended,
    nios2_oci_trace_capture_monitor_if.master       rd,
    output logic [$clog2(DEPTH):0]                  entry_count,
    output logic [15:0]                             total_count,
    output logic                                    overflow,
    output logic [BUF_W-1:0]                        signature,
    output logic                                    busy,
    output logic                                    done
);
    state_e             state_q, state_d;
    logic [CNT_W-1:0]   count_q;
    logic               ended_q;
    logic [15:0]        total_q;
    logic               ovf_q;
    logic [BUF_W-1:0]   sig_q;
    logic [SigMaxW-1:0] sig_rot;
    logic [BUF_W-1:0]   sig_next;

    logic ring_full, ring_empty;
    logic start, cap_event, accept, ovr, pop;

    assign start     = arm && ((state_q == StIdle) || (state_q == StDone));
    assign cap_event = (state_q == StCapture) && (dct_count != count_q);
    assign accept    = cap_event && (!ring_full || (OVERWRITE != 0));
    assign ovr       = cap_event && ring_full && (OVERWRITE != 0);
    assign rd.rd_valid = (state_q == StDrain) && !ring_empty;
    assign pop       = rd.rd_valid && rd.rd_ready;

    assign sig_rot  = sig_rotl1(SigMaxW'(sig_q), BUF_W);
    assign sig_next = sig_rot[BUF_W-1:0] ^ dct_buffer;

    nios2_oci_trace_ring #(
        .BUF_W (BUF_W),
        .DEPTH (DEPTH)
    ) u_ring (
        .clk       (clk),
        .reset_n   (reset_n),
        .clear     (start),
        .push      (accept),
        .overwrite (ovr),
        .pop       (pop),
        .wdata     (dct_buffer),
        .rdata     (rd.rd_data),
        .full      (ring_full),
        .empty     (ring_empty),
        .count     (entry_count)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:    if (arm) state_d = StCapture;
            StCapture: if (test_ending || test_has_ended) state_d = StDrain;
            StDrain:   if (ring_empty && ended_q) state_d = StDone;
            StDone:    if (arm) state_d = StCapture;
            default:   state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
            count_q <= '0;
            ended_q <= 1'b0;
            total_q <= '0;
            ovf_q   <= 1'b0;
            sig_q   <= '0;
        end else begin
            state_q <= state_d;
            // Sampled every cycle, so entering capture never sees a stale count.
            count_q <= dct_count;
            if (start) begin
                ended_q <= 1'b0;
                total_q <= '0;
                ovf_q   <= 1'b0;
                sig_q   <= '0;
            end else begin
                if (test_has_ended && (state_q != StIdle)) ended_q <= 1'b1;
                if (cap_event) total_q <= sat_inc16(total_q);
                if (cap_event && ring_full) ovf_q <= 1'b1;
                if (accept) sig_q <= sig_next;
            end
        end
    end

    assign total_count = total_q;
    assign overflow    = ovf_q;
    assign signature   = sig_q;
    assign busy        = (state_q == StCapture) || (state_q == StDrain);
    assign done        = (state_q == StDone);

endmodule
